// File: rtl/icache_refill_unit.sv
`default_nettype none
// ============================================================================
// Module   : icache_refill_unit
// Summary  : Instruction-cache line refill engine. Accepts one miss, issues a
//            line-aligned memory read, assembles the returned beats into a
//            line buffer and then pulses the data-array refill write port
//            for one cycle. Optional macro ICACHE_REFILL_ERR_EN adds
//            mem_resp_err_i / refill_err_o, which suppress the write when
//            any beat of the line reported an error.
// Revision : 1.0 - initial release
// ============================================================================
module icache_refill_unit #(
    parameter int NUM_WAYS            = 4,
    parameter int NUM_BANKS           = 4,
    parameter int SETS_PER_BANK_WIDTH = 8,
    parameter int BLOCK_WIDTH         = 512,
    parameter int MEM_DATA_WIDTH      = 64,
    parameter int ADDR_WIDTH          = 32
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    // miss request from the I-cache miss handler
    input  logic                           miss_valid_i,
    output logic                           miss_ready_o,
    input  logic [ADDR_WIDTH-1:0]          miss_addr_i,
    input  logic [$clog2(NUM_WAYS)-1:0]    miss_way_i,
    // memory request channel
    output logic                           mem_req_valid_o,
    input  logic                           mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0]          mem_req_addr_o,
    // memory response channel
    input  logic                           mem_resp_valid_i,
    output logic                           mem_resp_ready_o,
    input  logic [MEM_DATA_WIDTH-1:0]      mem_resp_data_i,
`ifdef ICACHE_REFILL_ERR_EN
    input  logic                           mem_resp_err_i,
    output logic                           refill_err_o,
`endif
    // data array refill write port
    output logic [SETS_PER_BANK_WIDTH-1:0] w_bank_addr_o,
    output logic [$clog2(NUM_BANKS)-1:0]   w_bank_sel_o,
    output logic [NUM_WAYS-1:0]            we_way_mask_o,
    output logic [BLOCK_WIDTH-1:0]         wdata_o,
    output logic                           refill_done_o,
    output logic                           busy_o
);

    localparam int c_OFF    = $clog2(BLOCK_WIDTH / 8);
    localparam int c_BANK_W = $clog2(NUM_BANKS);
    localparam int c_WAY_W  = $clog2(NUM_WAYS);
    localparam int c_BEATS  = BLOCK_WIDTH / MEM_DATA_WIDTH;
    localparam int c_CNT_W  = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;

    localparam logic [ADDR_WIDTH-1:0] c_OFF_MASK  = ADDR_WIDTH'((64'd1 << c_OFF) - 64'd1);
    localparam logic [c_CNT_W-1:0]    c_LAST_BEAT = c_CNT_W'(c_BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_FILL  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t                         r_state;
    logic [c_CNT_W-1:0]             r_cnt;
    logic [BLOCK_WIDTH-1:0]         r_line;
    logic [ADDR_WIDTH-1:0]          r_addr;
    logic [c_BANK_W-1:0]            r_bank;
    logic [SETS_PER_BANK_WIDTH-1:0] r_set;
    logic [c_WAY_W-1:0]             r_way;
    logic                           r_err;
    logic                           r_miss_ready;
    logic                           r_req_valid;
    logic                           r_resp_ready;
    logic [NUM_WAYS-1:0]            r_we_mask;
    logic                           r_done;
    logic                           r_busy;
`ifdef ICACHE_REFILL_ERR_EN
    logic                           r_err_out;
`endif

    logic w_beat_err;
    logic w_beat_acc;
    logic w_line_err;

`ifdef ICACHE_REFILL_ERR_EN
    assign w_beat_err = mem_resp_err_i;
`else
    assign w_beat_err = 1'b0;
`endif

    assign w_beat_acc = (r_state == S_FILL) && mem_resp_valid_i;
    // Error status of the whole line including the beat accepted this cycle
    assign w_line_err = r_err | w_beat_err;

    // Refill sequencer: all handshake and write-port outputs are registered
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_line       <= '0;
            r_addr       <= '0;
            r_bank       <= '0;
            r_set        <= '0;
            r_way        <= '0;
            r_err        <= 1'b0;
            r_miss_ready <= 1'b1;
            r_req_valid  <= 1'b0;
            r_resp_ready <= 1'b0;
            r_we_mask    <= '0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
`ifdef ICACHE_REFILL_ERR_EN
            r_err_out    <= 1'b0;
`endif
        end else begin
            // write strobes are single-cycle pulses
            r_we_mask <= '0;
            r_done    <= 1'b0;
`ifdef ICACHE_REFILL_ERR_EN
            r_err_out <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (miss_valid_i) begin
                        r_addr       <= miss_addr_i & ~c_OFF_MASK;
                        r_bank       <= miss_addr_i[c_OFF +: c_BANK_W];
                        r_set        <= miss_addr_i[c_OFF + c_BANK_W +: SETS_PER_BANK_WIDTH];
                        r_way        <= miss_way_i;
                        r_miss_ready <= 1'b0;
                        r_req_valid  <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_req_ready_i) begin
                        r_req_valid  <= 1'b0;
                        r_resp_ready <= 1'b1;
                        r_state      <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (w_beat_acc) begin
                        r_line[r_cnt * MEM_DATA_WIDTH +: MEM_DATA_WIDTH] <= mem_resp_data_i;
                        r_err <= w_line_err;
                        if (r_cnt == c_LAST_BEAT) begin
                            r_cnt        <= '0;
                            r_resp_ready <= 1'b0;
                            r_done       <= 1'b1;
                            // an errored line is consumed but never written
                            r_we_mask    <= w_line_err ? '0 : (NUM_WAYS'(1) << r_way);
`ifdef ICACHE_REFILL_ERR_EN
                            r_err_out    <= w_line_err;
`endif
                            r_state      <= S_WRITE;
                        end else begin
                            r_cnt <= r_cnt + c_CNT_W'(1);
                        end
                    end
                end
                S_WRITE: begin
                    r_err        <= 1'b0;
                    r_busy       <= 1'b0;
                    r_miss_ready <= 1'b1;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_miss_ready <= 1'b1;
                    r_req_valid  <= 1'b0;
                    r_resp_ready <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign miss_ready_o     = r_miss_ready;
    assign mem_req_valid_o  = r_req_valid;
    assign mem_req_addr_o   = r_addr;
    assign mem_resp_ready_o = r_resp_ready;
    assign w_bank_addr_o    = r_set;
    assign w_bank_sel_o     = r_bank;
    assign we_way_mask_o    = r_we_mask;
    assign wdata_o          = r_line;
    assign refill_done_o    = r_done;
    assign busy_o           = r_busy;
`ifdef ICACHE_REFILL_ERR_EN
    assign refill_err_o     = r_err_out;
`endif

endmodule
`default_nettype wire

// File: tb/tb_icache_refill_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_refill_unit
// Summary  : Scoreboard bench for icache_refill_unit. A driver issues misses
//            and memory traffic; a monitor compares requests and refill
//            writes against expectations computed from address arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_icache_refill_unit;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         miss_valid_i;
    logic         miss_ready_o;
    logic [31:0]  miss_addr_i;
    logic [1:0]   miss_way_i;
    logic         mem_req_valid_o;
    logic         mem_req_ready_i;
    logic [31:0]  mem_req_addr_o;
    logic         mem_resp_valid_i;
    logic         mem_resp_ready_o;
    logic [63:0]  mem_resp_data_i;
    logic [7:0]   w_bank_addr_o;
    logic [1:0]   w_bank_sel_o;
    logic [3:0]   we_way_mask_o;
    logic [511:0] wdata_o;
    logic         refill_done_o;
    logic         busy_o;
`ifdef ICACHE_REFILL_ERR_EN
    logic         mem_resp_err_i;
    logic         refill_err_o;
`endif

    icache_refill_unit dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .miss_valid_i     (miss_valid_i),
        .miss_ready_o     (miss_ready_o),
        .miss_addr_i      (miss_addr_i),
        .miss_way_i       (miss_way_i),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_req_addr_o   (mem_req_addr_o),
        .mem_resp_valid_i (mem_resp_valid_i),
        .mem_resp_ready_o (mem_resp_ready_o),
        .mem_resp_data_i  (mem_resp_data_i),
`ifdef ICACHE_REFILL_ERR_EN
        .mem_resp_err_i   (mem_resp_err_i),
        .refill_err_o     (refill_err_o),
`endif
        .w_bank_addr_o    (w_bank_addr_o),
        .w_bank_sel_o     (w_bank_sel_o),
        .we_way_mask_o    (we_way_mask_o),
        .wdata_o          (wdata_o),
        .refill_done_o    (refill_done_o),
        .busy_o           (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]   bank;
        logic [7:0]   set;
        logic [3:0]   mask;
        logic [511:0] data;
        bit           err;
        int           t_acc;
        bit           chk_lat;
    } wr_t;

    wr_t         wr_q[$];
    logic [31:0] req_q[$];
    logic [63:0] cur_beats[8];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic chkw(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: compares every request handshake and every refill write
    always @(negedge clk_i) begin : mon
        wr_t         w;
        logic [31:0] a;
        if (!rst_i) begin
            if (mem_req_valid_o && mem_req_ready_i) begin
                if (req_q.size() == 0) chk("req_unexpected", 32'(mem_req_valid_o), 32'(0));
                else begin
                    a = req_q.pop_front();
                    chk("req_addr", mem_req_addr_o, a);
                end
            end
            if (refill_done_o) begin
                if (wr_q.size() == 0) chk("done_unexpected", 32'(refill_done_o), 32'(0));
                else begin
                    w = wr_q.pop_front();
                    chk("bank_sel", 32'(w_bank_sel_o), 32'(w.bank));
                    chk("bank_addr", 32'(w_bank_addr_o), 32'(w.set));
                    chk("way_mask", 32'(we_way_mask_o), 32'(w.mask));
                    if (!w.err) chkw("wdata", wdata_o, w.data);
`ifdef ICACHE_REFILL_ERR_EN
                    chk("refill_err", 32'(refill_err_o), 32'(w.err));
`endif
                    if (w.chk_lat) chk("latency", 32'(cyc - w.t_acc), 32'(10));
                end
            end else if (we_way_mask_o != 4'd0) begin
                chk("stray_mask", 32'(we_way_mask_o), 32'(0));
            end
        end
    end

    task automatic check_reset_vals();
        chk("rst_miss_ready", 32'(miss_ready_o), 32'(1));
        chk("rst_busy", 32'(busy_o), 32'(0));
        chk("rst_req_valid", 32'(mem_req_valid_o), 32'(0));
        chk("rst_resp_ready", 32'(mem_resp_ready_o), 32'(0));
        chk("rst_req_addr", mem_req_addr_o, 32'(0));
        chk("rst_mask", 32'(we_way_mask_o), 32'(0));
        chk("rst_done", 32'(refill_done_o), 32'(0));
        chk("rst_bank_addr", 32'(w_bank_addr_o), 32'(0));
        chk("rst_bank_sel", 32'(w_bank_sel_o), 32'(0));
        chkw("rst_wdata", wdata_o, 512'(0));
    endtask

    // One refill: wait for idle, issue miss, serve request and beats
    task automatic refill(input logic [31:0] addr, input logic [1:0] way,
                          input int req_wait, input int gap_pct, input bit lat_chk,
                          input int abort_at, input int err_beat, input bit junk,
                          input bit hold, input logic [31:0] naddr, input logic [1:0] nway);
        wr_t          e;
        logic [511:0] d;
        int           guard;
        int           k;
        int           b;
        bit           hs;
        bit           v;
        bit           acc;
        guard = 0;
        while (!miss_ready_o) begin
            @(posedge clk_i); #1;
            guard++;
            if (guard > 200) begin
                chk("idle_timeout", 32'(miss_ready_o), 32'(1));
                return;
            end
        end
        miss_valid_i = 1'b1;
        miss_addr_i  = addr;
        miss_way_i   = way;
        d = '0;
        for (int i = 0; i < 8; i++) d = d | ({448'd0, cur_beats[i]} << (64 * i));
        e.bank    = 2'((addr / 64) % 4);
        e.set     = 8'((addr / 256) % 256);
        e.err     = (err_beat >= 0);
        e.mask    = e.err ? 4'd0 : 4'(1 << way);
        e.data    = d;
        e.t_acc   = cyc;
        e.chk_lat = lat_chk;
        wr_q.push_back(e);
        req_q.push_back(addr - (addr % 64));
        @(posedge clk_i); #1;
        if (hold) begin
            miss_addr_i = naddr;
            miss_way_i  = nway;
        end else begin
            miss_valid_i = 1'b0;
        end
        chk("req_valid_after_accept", 32'(mem_req_valid_o), 32'(1));
        chk("miss_ready_after_accept", 32'(miss_ready_o), 32'(0));
        k = 0;
        forever begin
            mem_req_ready_i = (k >= req_wait);
            if (junk) begin
                mem_resp_valid_i = 1'b1;
                mem_resp_data_i  = {$urandom, $urandom};
            end
            if (k > 0 && k < req_wait) begin
                chk("req_hold_valid", 32'(mem_req_valid_o), 32'(1));
                chk("req_hold_addr", mem_req_addr_o, addr - (addr % 64));
                chk("no_beat_in_req", 32'(mem_resp_ready_o), 32'(0));
            end
            hs = mem_req_valid_o && mem_req_ready_i;
            @(posedge clk_i); #1;
            if (hs) break;
            k++;
            if (k > req_wait + 50) begin
                chk("req_timeout", 32'(hs), 32'(1));
                return;
            end
        end
        mem_req_ready_i  = 1'b0;
        mem_resp_valid_i = 1'b0;
        chk("resp_ready_after_req", 32'(mem_resp_ready_o), 32'(1));
        b = 0;
        guard = 0;
        while (b < 8) begin
            if (abort_at == b) begin
                miss_valid_i     = 1'b0;
                rst_i            = 1'b1;
                mem_resp_valid_i = 1'b1;
                mem_resp_data_i  = cur_beats[b];
                @(posedge clk_i); #1;
                rst_i            = 1'b0;
                mem_resp_valid_i = 1'b0;
                void'(wr_q.pop_back());
                check_reset_vals();
                return;
            end
            v = ($urandom_range(99) >= gap_pct);
            mem_resp_valid_i = v;
            mem_resp_data_i  = v ? cur_beats[b] : {$urandom, $urandom};
`ifdef ICACHE_REFILL_ERR_EN
            mem_resp_err_i   = v && (b == err_beat);
`endif
            if (hold) chk("miss_ready_low_busy", 32'(miss_ready_o), 32'(0));
            acc = v && mem_resp_ready_o;
            @(posedge clk_i); #1;
            if (acc) b++;
            guard++;
            if (guard > 500) begin
                chk("beat_timeout", 32'(b), 32'(8));
                return;
            end
        end
        mem_resp_valid_i = 1'b0;
`ifdef ICACHE_REFILL_ERR_EN
        mem_resp_err_i   = 1'b0;
`endif
        chk("done_pulse", 32'(refill_done_o), 32'(1));
        chk("resp_ready_in_write", 32'(mem_resp_ready_o), 32'(0));
        chk("miss_ready_in_write", 32'(miss_ready_o), 32'(0));
        @(posedge clk_i); #1;
        chk("done_one_cycle", 32'(refill_done_o), 32'(0));
        chk("mask_cleared", 32'(we_way_mask_o), 32'(0));
        chk("miss_ready_after_write", 32'(miss_ready_o), 32'(1));
    endtask

    task automatic rand_beats();
        for (int i = 0; i < 8; i++) cur_beats[i] = {$urandom, $urandom};
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        logic [31:0] a2;
        rst_i            = 1'b1;
        miss_valid_i     = 1'b0;
        miss_addr_i      = '0;
        miss_way_i       = '0;
        mem_req_ready_i  = 1'b0;
        mem_resp_valid_i = 1'b0;
        mem_resp_data_i  = '0;
`ifdef ICACHE_REFILL_ERR_EN
        mem_resp_err_i   = 1'b0;
`endif
        repeat (3) @(posedge clk_i);
        #1;
        check_reset_vals();
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        // directed zero-wait refill with beat k = k
        for (int i = 0; i < 8; i++) cur_beats[i] = 64'(i);
        refill(32'h0000_1A7C, 2'd2, 0, 0, 1'b1, -1, -1, 1'b0, 1'b0, 32'd0, 2'd0);

        // stalled request with beats offered during the stall
        rand_beats();
        refill($urandom, 2'($urandom_range(3)), 5, 0, 1'b0, -1, -1, 1'b1, 1'b0, 32'd0, 2'd0);

        // miss held high across a refill with gapped beats
        rand_beats();
        a2 = $urandom;
        refill($urandom, 2'd1, 1, 40, 1'b0, -1, -1, 1'b0, 1'b1, a2, 2'd3);
        rand_beats();
        refill(a2, 2'd3, 0, 40, 1'b0, -1, -1, 1'b0, 1'b0, 32'd0, 2'd0);

        // reset during beat 4, then a complete refill
        rand_beats();
        refill($urandom, 2'd0, 0, 20, 1'b0, 4, -1, 1'b0, 1'b0, 32'd0, 2'd0);
        rand_beats();
        refill($urandom, 2'd0, 2, 20, 1'b0, -1, -1, 1'b0, 1'b0, 32'd0, 2'd0);

`ifdef ICACHE_REFILL_ERR_EN
        // errored beat 3 suppresses the write; next line writes normally
        rand_beats();
        refill($urandom, 2'd1, 0, 20, 1'b0, -1, 3, 1'b0, 1'b0, 32'd0, 2'd0);
        rand_beats();
        refill($urandom, 2'd1, 0, 20, 1'b0, -1, -1, 1'b0, 1'b0, 32'd0, 2'd0);
`endif

        // randomized refills
        for (int n = 0; n < 20; n++) begin
            rand_beats();
            refill($urandom, 2'($urandom_range(3)), $urandom_range(3), $urandom_range(50),
                   1'b0, -1, -1, 1'b0, 1'b0, 32'd0, 2'd0);
        end

        repeat (5) @(posedge clk_i);
        #1;
        chk("wr_queue_drained", 32'(wr_q.size()), 32'(0));
        chk("req_queue_drained", 32'(req_q.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
